// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A single 1-bit full-adder cell plus a carry
// flop processes one operand bit per clock, LSB first. Once all WIDTH bits
// have been processed, the registered sum and carry-out are updated and
// done pulses for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  begin an addition (sampled only while busy=0)
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while an addition is in progress
//   done   one-cycle pulse; sum/cout valid from this cycle on
//   sum    registered result (a+b+cin) mod 2^WIDTH
//   cout   registered carry-out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter must hold 0..WIDTH-1 and be at least one bit wide.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Full-adder cell, result shift-in value and next-state decode.
    // res_next already contains the bit being produced this cycle, so on
    // the final bit it is the complete sum.
    always_comb begin
        fa_sum     = a_sh[0] ^ b_sh[0] ^ carry;
        fa_cout    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_next   = res_sh >> 1;
        res_next[WIDTH-1] = fa_sum;
        accept     = (state == IDLE) && start;
        last_bit   = (state == RUN) && (cnt == LAST);
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, carry flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
        end
    end

    // Visible outputs only change on the final bit, so no partial result
    // ever appears on sum/cout while a run is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last_bit;
            if (last_bit) begin
                sum  <= res_next;
                cout <= fa_cout;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed self-checking bench for serial_adder. One instance at WIDTH=8
// and one at WIDTH=1 share clock and reset. Inputs change on the falling
// edge and outputs are sampled on the falling edge, midway between the
// active rising edges.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         checks;
    int         errors;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; presents a one-cycle start to the 8-bit
    // adder and returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = cv;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // One complete 8-bit addition: checks latency, busy duration, that the
    // previous result is held during the run, and the final result.
    // Optionally hammers start with new operands during the run.
    task automatic runAdd8(input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic [7:0] es,
                           input logic ec, input bit noise, input string tag);
        int cycles;
        int busy_cycles;
        bit hold_bad;
        cycles      = 0;
        busy_cycles = 0;
        hold_bad    = 1'b0;
        applyStimulus(av, bv, cv);
        checkOutput({tag, "_done_low_after_accept"}, 32'(done8), 32'd0);
        while (!done8 && cycles < 20) begin
            if (busy8) busy_cycles++;
            if (sum8 !== last_sum || cout8 !== last_cout) hold_bad = 1'b1;
            if (noise && cycles < 3) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
                cin8   = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start8 = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd8);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        checkOutput({tag, "_hold"}, 32'(hold_bad), 32'd0);
        checkOutput({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
        checkOutput({tag, "_sum"}, 32'(sum8), 32'(es));
        checkOutput({tag, "_cout"}, 32'(cout8), 32'(ec));
        last_sum  = es;
        last_cout = ec;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] fa_sum_tbl;
        logic [7:0] fa_cout_tbl;
        int         done_seen;

        checks    = 0;
        errors    = 0;
        last_sum  = 8'h00;
        last_cout = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;

        // Reset state, before any clock edge.
        rst = 1'b1;
        #3;
        checkOutput("rst_busy8", 32'(busy8), 32'd0);
        checkOutput("rst_done8", 32'(done8), 32'd0);
        checkOutput("rst_sum8",  32'(sum8),  32'd0);
        checkOutput("rst_cout8", 32'(cout8), 32'd0);
        checkOutput("rst_busy1", 32'(busy1), 32'd0);
        checkOutput("rst_sum1",  32'(sum1),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0xFF + 0x01 + 0 = 0x100
        runAdd8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_1");
        @(negedge clk);
        checkOutput("ff_plus_1_done_pulse", 32'(done8), 32'd0);
        checkOutput("ff_plus_1_sum_hold", 32'(sum8), 32'h00);
        checkOutput("ff_plus_1_cout_hold", 32'(cout8), 32'd1);

        // 0xA5 + 0x5A + 1 = 0x100, then 0x0F + 0x01 = 0x010
        runAdd8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "a5_5a_c1");
        @(negedge clk);
        @(negedge clk);
        runAdd8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "0f_plus_1");
        @(negedge clk);

        // start during RUN is ignored: 0x03 + 0x04 = 0x07
        runAdd8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1, "ignore_start");
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        checkOutput("ignore_start_extra_done", 32'(done_seen), 32'd0);
        checkOutput("ignore_start_idle", 32'(busy8), 32'd0);

        // Back-to-back: second start issued in the done cycle.
        // 0x10 + 0x20 + 1 = 0x31, then 0x80 + 0x80 = 0x100
        runAdd8(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, "b2b_first");
        runAdd8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "b2b_second");
        @(negedge clk);

        // Asynchronous reset in cycle 4 of RUN.
        applyStimulus(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy8), 32'd0);
        checkOutput("midrst_done", 32'(done8), 32'd0);
        checkOutput("midrst_sum",  32'(sum8),  32'd0);
        checkOutput("midrst_cout", 32'(cout8), 32'd1 - 32'd1);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        checkOutput("midrst_no_done", 32'(done_seen), 32'd0);
        last_sum  = 8'h00;
        last_cout = 1'b0;
        runAdd8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_rst");
        @(negedge clk);

        // WIDTH=1: full-adder truth table, index = {a, b, cin}.
        fa_sum_tbl  = 8'b1001_0110;
        fa_cout_tbl = 8'b1110_1000;
        for (int idx = 0; idx < 8; idx++) begin
            start1 = 1'b1;
            a1     = idx[2];
            b1     = idx[1];
            cin1   = idx[0];
            @(negedge clk);
            start1 = 1'b0;
            checkOutput($sformatf("w1_busy_%0d", idx), 32'(busy1), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("w1_done_%0d", idx), 32'(done1), 32'd1);
            checkOutput($sformatf("w1_sum_%0d", idx), 32'(sum1), 32'(fa_sum_tbl[idx]));
            checkOutput($sformatf("w1_cout_%0d", idx), 32'(cout1), 32'(fa_cout_tbl[idx]));
            @(negedge clk);
            checkOutput($sformatf("w1_done_clear_%0d", idx), 32'(done1), 32'd0);
        end

        $display("[TB] pass flag = %0d", (errors == 0) ? 1 : 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell plus a carry flip-flop.
- Accepts two N-bit operands and a carry-in through a start handshake.
- Adds one bit per clock, LSB first, then presents the registered N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the full-adder cell: it is the sequential wrapper that feeds that cell one bit per cycle and consumes its sum and carry.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin an addition; sampled only when busy=0
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle onward
- sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH
- cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset (async, rst=1) forces the following, independent of clk:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry flop and bit counter cleared
- States: IDLE, RUN.
- Bit counter width is max(1, clog2(WIDTH)).
- IDLE:
  - On an edge with start=1, latch a, b, cin into the operand shift registers and carry flop.
  - Clear the bit counter, go to RUN; busy=1 from the next cycle.
  - start=0: remain in IDLE; outputs hold their last values.
- RUN (one bit per edge):
  - fa_sum = a_sh[0]^b_sh[0]^carry
  - fa_cout = majority(a_sh[0], b_sh[0], carry)
  - fa_sum is shifted into the MSB of the result shift register; a_sh and b_sh shift right by 1; carry <= fa_cout; counter increments.
- Completion:
  - On the edge where counter==WIDTH-1: sum <= final result register, cout <= fa_cout, done <= 1, busy <= 0, state <= IDLE.
- Latency:
  - Accepting edge E0; done is high in the cycle following edge E_WIDTH, i.e. exactly WIDTH cycles after the accepting edge.
  - Throughput is one addition per WIDTH+1 cycles with back-to-back starts.
- done: high for exactly one cycle, then cleared on the next edge.
- Output hold: sum and cout keep their values until the next completion or reset; they do not change during RUN (no intermediate values visible).
- start while busy=1: ignored. No queueing; the operation in flight and its operands are unaffected by changes on a, b, cin.
- start in the done cycle: state is already IDLE, so it is accepted; the new run begins and done drops on that same edge.
- Reset mid-RUN: the operation is aborted; outputs return to 0; no done pulse is generated.
- WIDTH=1: a single RUN cycle; the block degenerates to a registered full adder with 1-cycle latency.
- Arithmetic: {cout,sum} == a + b + cin (zero-extended to WIDTH+1 bits); no saturation.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, start pulsed 1 cycle -> busy high for 8 cycles; done pulse 8 cycles after the accepting edge; sum=0x00, cout=1.
- WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0; sum/cout hold their values until the next done.
- WIDTH=8: start a=0x03, b=0x04, cin=0, then during RUN drive start=1 with a=0xFF, b=0xFF -> the second start is ignored; result sum=0x07, cout=0; exactly one done pulse.
- WIDTH=8: start a=0x10, b=0x20, cin=1, then assert start again in the done cycle with a=0x80, b=0x80, cin=0:
  - first result sum=0x31, cout=0;
  - second run accepted with no idle gap; sum=0x00, cout=1 after 8 more cycles.
- WIDTH=8: start an addition, assert rst asynchronously (between clock edges) at cycle 4 of RUN -> busy, done, sum, cout go to 0 immediately; no done pulse follows; the next start after rst release gives a correct result.
- WIDTH=1: all 8 combinations of (a,b,cin) -> after 1 cycle:
  - (1,1,1) gives sum=1, cout=1
  - (1,1,0) gives sum=0, cout=1
  - (0,1,0) gives sum=1, cout=0
  - (0,0,0) gives sum=0, cout=0
  - the remaining combinations match the full-adder truth table.
  - The bench keeps a pass flag and prints it at the end.
